mismatch_irq_ctrl: RTL and testbench

Multi-channel successor to the single-pair data-compare interrupt. Each of CHANNELS lanes compares two WIDTH-bit words on its read strobe and counts consecutive mismatching strobes. When a lane reaches THRESH, it latches a pending flag and captures the offending XOR pattern. A masked OR of the pending flags drives one registered interrupt line to the processor. Pending flags clear by acknowledge, or automatically in non-sticky mode.

---
 rtl/mismatch_irq_ctrl_pkg.sv | 26 ++
 rtl/mismatch_irq_ctrl_lane.sv | 110 +++++++++++
 rtl/mismatch_irq_ctrl.sv | 90 +++++++++
 tb/tb_mismatch_irq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mismatch_irq_ctrl_pkg.sv
// mismatch_irq_pkg
// Shared definitions for the multi-channel data-compare interrupt controller:
//   lane_state_e : per-lane FSM state (IDLE, RUN, PEND), 2 bits
//   RUN_W        : width of the per-lane consecutive-mismatch counter
//   popcount     : number of set bits in a vector of up to POP_MAX_W lanes
package mismatch_irq_pkg;

   typedef enum logic [1:0] {
      LANE_IDLE = 2'd0,
      LANE_RUN  = 2'd1,
      LANE_PEND = 2'd2
   } lane_state_e;

   localparam int unsigned RUN_W     = 8;
   localparam int unsigned POP_MAX_W = 32;

   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < POP_MAX_W; i++) begin
         n = n + {31'd0, vec[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/mismatch_irq_ctrl_lane.sv
// mismatch_lane
// One compare lane: counts consecutive mismatching strobes, latches pending
// at THRESH and captures the triggering XOR pattern.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   data_1_i/2_i   : operands compared when strobe_i is high
//   strobe_i       : compare qualifier
//   sticky_i       : 1 = pending held until ack, 0 = matching strobe also clears
//   ack_i          : acknowledge for this lane (already qualified by ack_sel)
//   pending_o      : registered pending flag
//   diff_cap_o     : XOR captured at the last trigger
//   trigger_o      : lane enters PEND at the coming edge
//   pend_next_o    : pending value after the coming edge
module mismatch_lane
   import mismatch_irq_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned THRESH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_1_i,
   input  logic [WIDTH-1:0] data_2_i,
   input  logic             strobe_i,
   input  logic             sticky_i,
   input  logic             ack_i,
   output logic             pending_o,
   output logic [WIDTH-1:0] diff_cap_o,
   output logic             trigger_o,
   output logic             pend_next_o
);

   localparam logic [RUN_W-1:0] THRESH_V = RUN_W'(THRESH);

   lane_state_e      state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] diff;
   logic             mism;
   logic             trig;

   assign diff = data_1_i ^ data_2_i;
   assign mism = |diff;

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      cap_d   = cap_q;
      trig    = 1'b0;
      case (state_q)
         LANE_IDLE: begin
            if (strobe_i && mism) begin
               if (THRESH_V == 8'd1) begin
                  trig = 1'b1;
               end else begin
                  state_d = LANE_RUN;
                  run_d   = 8'd1;
               end
            end
         end
         LANE_RUN: begin
            if (strobe_i) begin
               if (mism) begin
                  if (run_q + 8'd1 == THRESH_V) begin
                     trig = 1'b1;
                  end else begin
                     run_d = run_q + 8'd1;
                  end
               end else begin
                  state_d = LANE_IDLE;
                  run_d   = '0;
               end
            end
         end
         LANE_PEND: begin
            // Strobes are never counted here; they can only clear in non-sticky mode.
            if (ack_i || (!sticky_i && strobe_i && !mism)) begin
               state_d = LANE_IDLE;
            end
         end
         default: begin
            state_d = LANE_IDLE;
            run_d   = '0;
         end
      endcase
      if (trig) begin
         state_d = LANE_PEND;
         run_d   = '0;
         cap_d   = diff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LANE_IDLE;
         run_q   <= '0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         cap_q   <= cap_d;
      end
   end

   assign pending_o   = (state_q == LANE_PEND);
   assign diff_cap_o  = cap_q;
   assign trigger_o   = trig;
   assign pend_next_o = (state_d == LANE_PEND);

endmodule

// File: rtl/mismatch_irq_ctrl.sv
// mismatch_irq_ctrl
// Multi-channel data-compare interrupt controller. CHANNELS independent lanes
// compare data_1/data_2 on their read strobe; a masked OR of the lane pending
// flags drives one registered interrupt line.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   data_1/2    : packed operands, lane i at [i*WIDTH +: WIDTH]
//   read_strobe : per-lane compare qualifier
//   irq_mask    : per-lane interrupt enable (does not gate pending)
//   sticky      : 1 = pending held until ack
//   ack/ack_sel : clear pending on the selected lanes
//   interrupt   : registered OR of pending & irq_mask
//   pending     : per-lane pending flags
//   diff_cap    : per-lane captured XOR at trigger
//   event_cnt   : saturating count of pending-set events
module mismatch_irq_ctrl
   import mismatch_irq_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned THRESH   = 1,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] data_1,
   input  logic [CHANNELS*WIDTH-1:0] data_2,
   input  logic [CHANNELS-1:0]       read_strobe,
   input  logic [CHANNELS-1:0]       irq_mask,
   input  logic                      sticky,
   input  logic                      ack,
   input  logic [CHANNELS-1:0]       ack_sel,
   output logic                      interrupt,
   output logic [CHANNELS-1:0]       pending,
   output logic [CHANNELS*WIDTH-1:0] diff_cap,
   output logic [CNT_W-1:0]          event_cnt
);

   localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

   logic [CHANNELS-1:0] trig;
   logic [CHANNELS-1:0] pend_next;
   logic [CNT_W:0]      cnt_sum;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                irq_q, irq_d;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      mismatch_lane #(
         .WIDTH  (WIDTH),
         .THRESH (THRESH)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .data_1_i    (data_1[g*WIDTH +: WIDTH]),
         .data_2_i    (data_2[g*WIDTH +: WIDTH]),
         .strobe_i    (read_strobe[g]),
         .sticky_i    (sticky),
         .ack_i       (ack & ack_sel[g]),
         .pending_o   (pending[g]),
         .diff_cap_o  (diff_cap[g*WIDTH +: WIDTH]),
         .trigger_o   (trig[g]),
         .pend_next_o (pend_next[g])
      );
   end

   // Sum is one bit wider than the counter so overflow is seen before saturating.
   always_comb begin
      cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(popcount(POP_MAX_W'(trig)));
      if (cnt_sum > CNT_MAX) begin
         cnt_d = '1;
      end else begin
         cnt_d = cnt_sum[CNT_W-1:0];
      end
      irq_d = |(pend_next & irq_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         irq_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         irq_q <= irq_d;
      end
   end

   assign event_cnt = cnt_q;
   assign interrupt = irq_q;

endmodule

// File: tb/tb_mismatch_irq_ctrl.sv
// tb_mismatch_irq_ctrl
// Three controllers (THRESH = 1, 2, 3) share one stimulus stream and are each
// checked every cycle against a streak-counting reference model, plus directed
// scenarios with fixed expected values.
module tb_mismatch_irq_ctrl;

   localparam int ND = 3;
   localparam int NL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] d1, d2;
   logic [3:0]  strobe, mask, sel;
   logic        sticky, ack;

   logic        irq_w  [ND];
   logic [3:0]  pend_w [ND];
   logic [31:0] cap_w  [ND];
   logic [7:0]  cnt_w  [ND];

   int checks = 0;
   int errors = 0;

   // reference model
   int       streak [ND][NL];
   bit       mp     [ND][NL];
   bit [7:0] mc     [ND][NL];
   int       mcnt   [ND];
   bit       mi     [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      mismatch_irq_ctrl #(
         .WIDTH    (8),
         .CHANNELS (4),
         .THRESH   (g + 1),
         .CNT_W    (8)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .data_1      (d1),
         .data_2      (d2),
         .read_strobe (strobe),
         .irq_mask    (mask),
         .sticky      (sticky),
         .ack         (ack),
         .ack_sel     (sel),
         .interrupt   (irq_w[g]),
         .pending     (pend_w[g]),
         .diff_cap    (cap_w[g]),
         .event_cnt   (cnt_w[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < ND; d++) begin
         int ntrig;
         ntrig = 0;
         for (int l = 0; l < NL; l++) begin
            bit [7:0] diff;
            bit       mm;
            diff = d1[l*8 +: 8] ^ d2[l*8 +: 8];
            mm   = (diff != 8'd0);
            if (rst) begin
               streak[d][l] = 0;
               mp[d][l]     = 1'b0;
               mc[d][l]     = 8'd0;
            end else if (mp[d][l]) begin
               if ((ack && sel[l]) || (!sticky && strobe[l] && !mm)) mp[d][l] = 1'b0;
            end else if (strobe[l]) begin
               if (mm) begin
                  streak[d][l]++;
                  if (streak[d][l] >= d + 1) begin
                     mp[d][l]     = 1'b1;
                     streak[d][l] = 0;
                     mc[d][l]     = diff;
                     ntrig++;
                  end
               end else begin
                  streak[d][l] = 0;
               end
            end
         end
         if (rst) mcnt[d] = 0;
         else     mcnt[d] = (mcnt[d] + ntrig > 255) ? 255 : mcnt[d] + ntrig;
         mi[d] = 1'b0;
         if (!rst) for (int l = 0; l < NL; l++) if (mp[d][l] && mask[l]) mi[d] = 1'b1;
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < ND; d++) begin
         logic [3:0]  ep;
         logic [31:0] ec;
         for (int l = 0; l < NL; l++) begin
            ep[l]        = mp[d][l];
            ec[l*8 +: 8] = mc[d][l];
         end
         check($sformatf("t%0d pending", d + 1), {28'd0, pend_w[d]}, {28'd0, ep});
         check($sformatf("t%0d interrupt", d + 1), {31'd0, irq_w[d]}, {31'd0, mi[d]});
         check($sformatf("t%0d event_cnt", d + 1), {24'd0, cnt_w[d]}, mcnt[d]);
         check($sformatf("t%0d diff_cap", d + 1), cap_w[d], ec);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      compare_all();
   endtask

   task automatic set_lane(input int l, input logic [7:0] a, input logic [7:0] b);
      d1[l*8 +: 8] = a;
      d2[l*8 +: 8] = b;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      strobe = '0;
      ack    = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic ack_all();
      strobe = '0;
      ack    = 1'b1;
      sel    = 4'hF;
      tick();
      ack = 1'b0;
      sel = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int pat [6];
      rst = 1'b1; d1 = '0; d2 = '0; strobe = '0; mask = 4'hF; sel = '0;
      sticky = 1'b1; ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset pending", {28'd0, pend_w[0]}, 32'd0);
      check("reset interrupt", {31'd0, irq_w[0]}, 32'd0);
      check("reset event_cnt", {24'd0, cnt_w[0]}, 32'd0);
      check("reset diff_cap", cap_w[0], 32'd0);

      // single trigger on lane 0, then ack
      set_lane(0, 8'hA5, 8'hA4);
      strobe = 4'b0001;
      tick();
      strobe = '0;
      check("trig pending", {28'd0, pend_w[0]}, 32'h1);
      check("trig diff_cap0", {24'd0, cap_w[0][7:0]}, 32'h01);
      check("trig interrupt", {31'd0, irq_w[0]}, 32'd1);
      check("trig event_cnt", {24'd0, cnt_w[0]}, 32'd1);
      ack = 1'b1; sel = 4'b0001;
      tick();
      ack = 1'b0; sel = '0;
      check("ack pending", {28'd0, pend_w[0]}, 32'd0);
      check("ack interrupt", {31'd0, irq_w[0]}, 32'd0);

      // THRESH=3 streak with a breaking match on lane 2
      do_reset();
      pat = '{1, 1, 0, 1, 1, 1};
      strobe = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         if (pat[i] != 0) set_lane(2, 8'h5A, 8'h5B);
         else             set_lane(2, 8'h5A, 8'h5A);
         tick();
         if (i == 4) check("thr3 early", {31'd0, pend_w[2][2]}, 32'd0);
         if (i == 5) begin
            check("thr3 pending", {31'd0, pend_w[2][2]}, 32'd1);
            check("thr3 event_cnt", {24'd0, cnt_w[2]}, 32'd1);
         end
      end
      strobe = '0;

      // non-sticky clear versus sticky hold on lane 1
      do_reset();
      sticky = 1'b0;
      set_lane(1, 8'h3C, 8'h3D);
      strobe = 4'b0010;
      tick();
      set_lane(1, 8'h3C, 8'h3C);
      tick();
      strobe = '0;
      check("nonsticky pending", {31'd0, pend_w[0][1]}, 32'd0);
      check("nonsticky diff_cap", {24'd0, cap_w[0][15:8]}, 32'h01);
      sticky = 1'b1;
      set_lane(1, 8'h3C, 8'h3D);
      strobe = 4'b0010;
      tick();
      set_lane(1, 8'h3C, 8'h3C);
      tick();
      strobe = '0;
      check("sticky pending", {31'd0, pend_w[0][1]}, 32'd1);

      // mask gates interrupt but not pending
      do_reset();
      mask = 4'b1110;
      set_lane(0, 8'hA5, 8'hA4);
      strobe = 4'b0001;
      tick();
      strobe = '0;
      check("mask pending", {28'd0, pend_w[0]}, 32'h1);
      check("mask interrupt", {31'd0, irq_w[0]}, 32'd0);
      mask = 4'hF;
      tick();
      check("unmask interrupt", {31'd0, irq_w[0]}, 32'd1);
      ack_all();

      // event counter saturation
      do_reset();
      d1 = 32'h11223344;
      d2 = d1 ^ 32'h01010101;
      for (int r = 0; r < 63; r++) begin
         strobe = 4'hF;
         tick();
         ack_all();
      end
      check("cnt 252", {24'd0, cnt_w[0]}, 32'd252);
      strobe = 4'b0001;
      tick();
      ack_all();
      check("cnt 253", {24'd0, cnt_w[0]}, 32'd253);
      strobe = 4'hF;
      tick();
      strobe = '0;
      check("cnt saturate", {24'd0, cnt_w[0]}, 32'd255);
      ack_all();
      strobe = 4'hF;
      tick();
      strobe = '0;
      check("cnt hold", {24'd0, cnt_w[0]}, 32'd255);
      ack_all();

      // reset overriding a mismatching strobe while lane 3 is in RUN (THRESH=2)
      do_reset();
      set_lane(3, 8'h0F, 8'hF0);
      strobe = 4'b1000;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      strobe = '0;
      check("rst pending", {28'd0, pend_w[1]}, 32'd0);
      check("rst interrupt", {31'd0, irq_w[1]}, 32'd0);
      check("rst event_cnt", {24'd0, cnt_w[1]}, 32'd0);
      check("rst diff_cap", cap_w[1], 32'd0);
      strobe = 4'b1000;
      tick();
      strobe = '0;
      check("rst no trigger", {31'd0, pend_w[1][3]}, 32'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         d1  = $urandom;
         for (int l = 0; l < NL; l++) begin
            if ($urandom_range(0, 2) == 0) d2[l*8 +: 8] = d1[l*8 +: 8];
            else                           d2[l*8 +: 8] = d1[l*8 +: 8] ^ 8'($urandom);
         end
         strobe = 4'($urandom);
         ack    = ($urandom_range(0, 3) == 0);
         sel    = 4'($urandom);
         if ($urandom_range(0, 15) == 0) sticky = ~sticky;
         if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
